ad7276_emulator: RTL and testbench
==================================

// Module: ad7276_emulator
// PURPOSE
//  Synthesizable dual-channel AD7276 serial-ADC responder for hardware-in-loop and loopback test.
//  Accepts samples over AXI-Stream, answers an external cs_n/sclk master with AD7276-format frames.
//  Drives two SDATA lines, matching the two-data-line-per-chip-select reader topology.
//  Sits at the board edge in place of a physical ADC pair.
// PARAMETERS
//  ADC_LENGTH   12  data bits per channel, MSB first
//  FRAME_BITS   16  SCLK falling edges per frame (2 lead zeros + ADC_LENGTH + trailing zeros)
//  SYNC_STAGES  2   synchronizer flops on cs_n and sclk (>=2)
//  AXIS_BYTES   4   s_axis tdata width in bytes (>=4)
// PORTS
//  clk            in   1              system clock (100 MHz); sole clock domain
//  sreset         in   1              synchronous, active-high reset
//  s_axis_tdata   in   AXIS_BYTES*8   [ADC_LENGTH-1:0]=ch A, [16+ADC_LENGTH-1:16]=ch B
//  s_axis_tvalid  in   1              sample valid
//  s_axis_tready  out  1              holding register empty
//  cs_n           in   1              chip select from master, async, active low
//  sclk           in   1              serial clock from master, async
//  sdata_a        out  1              serial data ch A
//  sdata_b        out  1              serial data ch B
//  sdata_oe       out  1              1 = drive pins, 0 = three-state (pad buffer external)
//  frame_active   out  1              high from CS fall to CS rise
//  underrun       out  1              1-cycle pulse: frame started with no fresh sample
//  aborted        out  1              1-cycle pulse: CS rose before FRAME_BITS falling edges
//  frame_count    out  32             completed frames, wraps 2^32-1 -> 0
// BEHAVIOUR
//  - Reset: all outputs 0, including s_axis_tready, sdata_oe and frame_count. Hold register empty; last sample = 0.
//    s_axis_tready goes to 1 on the first cycle after reset.
//  - cs_n and sclk pass through SYNC_STAGES flops plus one edge register.
//    Pin edge -> output update latency = SYNC_STAGES+1 clk.
//    Supported sclk high/low times are >= 4 clk.
//  - Handshake: one-entry hold register; tready = !hold_valid; transfer on tvalid&&tready.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE:
//    IDLE: oe=0. On CS fall: load shift regs {2'b00, data, zeros}, bit_cnt=0, oe=1, sdata=0 (first lead zero).
//      Data source priority:
//        - accepting beat this cycle (bypass; hold stays empty);
//        - else hold register (cleared);
//        - else last sample, with underrun pulse.
//      Go to SHIFT.
//    SHIFT: on each sclk fall, bit_cnt++ and shift left (MSB drives sdata).
//      On falling edge FRAME_BITS: oe=0, frame_count++, go to DONE.
//    DONE: wait for CS rise -> IDLE. Further sclk edges are ignored.
//    CS rise in SHIFT: oe=0, aborted pulse, frame_count unchanged, go to IDLE. Sample stays consumed.
//  - Events in the same cycle:
//    - CS rise and sclk fall together: CS rise wins.
//    - CS fall and sclk fall together: sclk edge ignored.
//  - sreset mid-frame: immediate return to reset state; oe=0 next cycle.
//  - last sample is updated at every frame load.
// CONFIGURATION
//  AD7276_EMU_TEST_PATTERN_EN defined:
//    - adds input pattern_en (1 bit).
//    - When pattern_en=1, each frame loads ch A = 12-bit counter, ch B = ~counter.
//    - The counter starts at 0 at reset and increments per frame load.
//    - AXIS is still accepted and discarded; underrun is never asserted.
//  Undefined: no pattern_en port and no counter logic; AXIS is the only data source.
// STRUCTURE
//  ad7276_emu_pkg:
//    - state_t enum {IDLE, SHIFT, DONE};
//    - localparams LEAD_ZEROS=2, TRAIL_ZEROS=FRAME_BITS-LEAD_ZEROS-ADC_LENGTH;
//    - bit_cnt width function $clog2(FRAME_BITS+1).
//  Sub-module ad7276_emu_sync: SYNC_STAGES synchronizer + rise/fall pulse outputs.
//    Instantiated twice (cs_n, sclk).
// TESTING
//  1. Push tdata=0x0ABC_0123, run 16-sclk frame at clk/10:
//     - sdata_a captured on sclk rise = 00_0001_0010_0011_00;
//     - sdata_b = 00_1010_1011_1100_00;
//     - oe=0 within 3 clk of 16th fall; frame_count=1.
//  2. Second frame with no new beat: ch A repeats 0x123; underrun high exactly 1 clk; frame_count=2.
//  3. CS rises after 7 sclk falls: aborted 1-clk pulse, oe=0, frame_count unchanged.
//     Next frame uses next queued sample.
//  4. Backpressure and bypass:
//     - hold full, tvalid held: tready=0 and the beat is not lost (it appears in the following frame).
//     - beat accepted on CS-fall cycle: used directly, no underrun.
//  5. sreset asserted at bit 9: all outputs 0, tready=1 next cycle, next frame uses last sample=0 with underrun.
//  6. With AD7276_EMU_TEST_PATTERN_EN and pattern_en=1, three frames:
//     - ch A = 0x000, 0x001, 0x002;
//     - ch B = 0xFFF, 0xFFE, 0xFFD.

Source files
------------

// File: rtl/ad7276_emu_pkg.sv
// ad7276_emu_pkg: shared configuration, types and helpers for the AD7276
// dual-channel ADC emulator.
//   ADC_LENGTH   data bits per channel (MSB first on the wire)
//   FRAME_BITS   sclk falling edges per frame
//   SYNC_STAGES  synchronizer depth on cs_n and sclk (>= 2)
//   AXIS_BYTES   sample-stream data width in bytes (>= 4)
package ad7276_emu_pkg;

  localparam int ADC_LENGTH  = 12;
  localparam int FRAME_BITS  = 16;
  localparam int SYNC_STAGES = 2;
  localparam int AXIS_BYTES  = 4;

  localparam int LEAD_ZEROS  = 2;
  localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - ADC_LENGTH;

  // Bit counter must be able to hold FRAME_BITS itself.
  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

  localparam int CNT_W = cnt_width(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    logic [ADC_LENGTH-1:0] b;
    logic [ADC_LENGTH-1:0] a;
  } sample_t;

  // Frame layout: LEAD_ZEROS zeros, the data word MSB first, then zeros.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [ADC_LENGTH-1:0] d);
    return FRAME_BITS'(d) << TRAIL_ZEROS;
  endfunction

endpackage

// File: rtl/ad7276_emulator_if.sv
// ad7276_emulator_if: AXI-Stream sample input for the AD7276 emulator.
//   tdata   [ADC_LENGTH-1:0] = channel A, [16+ADC_LENGTH-1:16] = channel B
//   tvalid  sample valid (master -> slave)
//   tready  emulator holding register empty (slave -> master)
interface ad7276_emulator_if;
  import ad7276_emu_pkg::*;

  logic [AXIS_BYTES*8-1:0] tdata;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ad7276_emu_sync.sv
// ad7276_emu_sync: brings an asynchronous pin into the clk domain through
// STAGES flops, then one edge register, and produces single-cycle edge pulses.
//   clk, sreset  system clock, synchronous active-high reset
//   async_in     asynchronous pin
//   rise, fall   one-cycle pulses, STAGES clk after the pin edge
// RESET_VAL is the pin's idle level so that leaving reset creates no edge.
module ad7276_emu_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic sreset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (sreset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ad7276_emulator.sv
// ad7276_emulator: dual-channel AD7276 serial-ADC responder. Samples arrive on
// an AXI-Stream slave; an external cs_n/sclk master reads AD7276-format frames
// on two data lines (one per channel) sharing one chip select.
//   clk, sreset       100 MHz system clock, synchronous active-high reset
//   s_axis            sample stream (slave modport)
//   pattern_en        only with AD7276_EMU_TEST_PATTERN_EN: counter test pattern
//   cs_n, sclk        asynchronous master pins
//   sdata_a/b         serial data, MSB first, updated after each sclk fall
//   sdata_oe          1 = drive the sdata pins, 0 = three-state
//   frame_active      high from CS fall to CS rise
//   underrun          1-cycle pulse: frame loaded the previous sample again
//   aborted           1-cycle pulse: CS rose before the frame was complete
//   frame_count       completed frames, wrapping
// Build option: define AD7276_EMU_TEST_PATTERN_EN to add the pattern_en input.
module ad7276_emulator
  import ad7276_emu_pkg::*;
(
  input  logic                  clk,
  input  logic                  sreset,
  ad7276_emulator_if.slave      s_axis,
`ifdef AD7276_EMU_TEST_PATTERN_EN
  input  logic                  pattern_en,
`endif
  input  logic                  cs_n,
  input  logic                  sclk,
  output logic                  sdata_a,
  output logic                  sdata_b,
  output logic                  sdata_oe,
  output logic                  frame_active,
  output logic                  underrun,
  output logic                  aborted,
  output logic [31:0]           frame_count
);

  logic cs_rise, cs_fall, sclk_fall, unused_sclk_rise;

  ad7276_emu_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .sreset(sreset), .async_in(cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  ad7276_emu_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .sreset(sreset), .async_in(sclk), .rise(unused_sclk_rise), .fall(sclk_fall)
  );

  state_t                state;
  logic [FRAME_BITS-1:0] shift_a, shift_b;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  hold_valid, tready_q;
  sample_t               hold, last;
`ifdef AD7276_EMU_TEST_PATTERN_EN
  logic [ADC_LENGTH-1:0] pat_cnt;
`endif

  // Only the two channel fields of tdata carry information.
  logic    unused_tdata;
  sample_t beat;
  assign unused_tdata = ^s_axis.tdata;
  assign beat.a = s_axis.tdata[ADC_LENGTH-1:0];
  assign beat.b = s_axis.tdata[16 +: ADC_LENGTH];

  logic    accept, load, starve, hold_valid_next;
  sample_t load_data;

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    accept    = s_axis.tvalid && tready_q;
    load      = (state == IDLE) && cs_fall;
    starve    = 1'b0;
    load_data = last;
    // Accepting implies the hold register is empty, so bypass is safe.
    if (accept) begin
      load_data = beat;
    end else if (hold_valid) begin
      load_data = hold;
    end else begin
      starve = 1'b1;
    end
`ifdef AD7276_EMU_TEST_PATTERN_EN
    if (pattern_en) begin
      load_data.a = pat_cnt;
      load_data.b = ~pat_cnt;
      starve      = 1'b0;
    end
`endif
    hold_valid_next = load ? 1'b0 : (hold_valid || accept);
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state        <= IDLE;
      shift_a      <= '0;
      shift_b      <= '0;
      bit_cnt      <= '0;
      hold_valid   <= 1'b0;
      tready_q     <= 1'b0;
      hold         <= '0;
      last         <= '0;
      sdata_oe     <= 1'b0;
      frame_active <= 1'b0;
      underrun     <= 1'b0;
      aborted      <= 1'b0;
      frame_count  <= '0;
`ifdef AD7276_EMU_TEST_PATTERN_EN
      pat_cnt      <= '0;
`endif
    end else begin
      // tready registered from the next hold state: low during reset, high
      // on the first cycle after it, and always equal to !hold_valid.
      hold_valid <= hold_valid_next;
      tready_q   <= !hold_valid_next;
      if (accept && !load) hold <= beat;
      underrun   <= 1'b0;
      aborted    <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            shift_a      <= frame_word(load_data.a);
            shift_b      <= frame_word(load_data.b);
            bit_cnt      <= '0;
            sdata_oe     <= 1'b1;
            frame_active <= 1'b1;
            underrun     <= starve;
            last         <= load_data;
`ifdef AD7276_EMU_TEST_PATTERN_EN
            pat_cnt      <= pat_cnt + 1'b1;
`endif
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          // CS rise outranks a simultaneous sclk fall.
          if (cs_rise) begin
            sdata_oe     <= 1'b0;
            frame_active <= 1'b0;
            aborted      <= 1'b1;
            shift_a      <= '0;
            shift_b      <= '0;
            state        <= IDLE;
          end else if (sclk_fall) begin
            shift_a <= shift_a << 1;
            shift_b <= shift_b << 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
              sdata_oe    <= 1'b0;
              frame_count <= frame_count + 32'd1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (cs_rise) begin
            frame_active <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_axis.tready = tready_q;
  assign sdata_a       = shift_a[FRAME_BITS-1];
  assign sdata_b       = shift_b[FRAME_BITS-1];

endmodule

// File: tb/tb_ad7276_emulator.sv
// tb_ad7276_emulator: directed test of the AD7276 emulator. An SPI-style master
// (sclk idle low, rises then falls, clk/10) reads frames and captures sdata on
// each sclk rise; a stream driver feeds samples from a queue.
module tb_ad7276_emulator;
  import ad7276_emu_pkg::*;

  logic        clk, sreset, cs_n, sclk;
  logic        sdata_a, sdata_b, sdata_oe, frame_active, underrun, aborted;
  logic [31:0] frame_count;
`ifdef AD7276_EMU_TEST_PATTERN_EN
  logic        pattern_en;
`endif

  ad7276_emulator_if axis ();

  ad7276_emulator dut (
    .clk(clk), .sreset(sreset), .s_axis(axis),
`ifdef AD7276_EMU_TEST_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .cs_n(cs_n), .sclk(sclk), .sdata_a(sdata_a), .sdata_b(sdata_b),
    .sdata_oe(sdata_oe), .frame_active(frame_active), .underrun(underrun),
    .aborted(aborted), .frame_count(frame_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_underrun = 0;
  int n_aborted  = 0;

  logic [31:0] q[$];
  logic [15:0] cap_a, cap_b;
  logic        oe_mid, oe_at2, oe_at3, oe_cs, fa_before, fa_after;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stream driver: retires the head after a handshake, presents the next beat.
  initial begin
    logic hs;
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    forever begin
      @(posedge clk);
      hs = axis.tvalid && axis.tready;
      #2;
      if (hs) void'(q.pop_front());
      axis.tvalid = (q.size() != 0);
      axis.tdata  = (q.size() != 0) ? q[0] : 32'h0;
    end
  end

  // Pulse monitor: counts cycles each pulse output is high.
  initial begin
    forever begin
      @(negedge clk);
      if (underrun) n_underrun++;
      if (aborted)  n_aborted++;
    end
  end

  task automatic wait_drained();
    int k = 0;
    while ((q.size() != 0 || axis.tvalid) && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 50) begin
      $display("FAIL drain_timeout: queue depth %0d, required 0", q.size());
      n_fail++;
    end
  endtask

  task automatic run_frame(input int nfalls, input bit bypass, input logic [31:0] bdata,
                           input bit raise_cs);
    cap_a = '0;
    cap_b = '0;
    oe_mid = 1'b0;
    @(negedge clk);
    cs_n = 1'b0;
    if (bypass) begin
      @(negedge clk);
      q.push_back(bdata);
    end
    repeat (8) @(negedge clk);
    for (int i = 0; i < nfalls; i++) begin
      sclk = 1'b1;
      cap_a = {cap_a[14:0], sdata_a};
      cap_b = {cap_b[14:0], sdata_b};
      if (i == 0) oe_mid = sdata_oe;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
      repeat (2) @(negedge clk);
      oe_at2 = sdata_oe;
      @(negedge clk);
      oe_at3 = sdata_oe;
      repeat (2) @(negedge clk);
    end
    fa_before = frame_active;
    if (raise_cs) begin
      cs_n = 1'b1;
      repeat (3) @(negedge clk);
      oe_cs    = sdata_oe;
      fa_after = frame_active;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (axis.tready !== 1'b0) begin $display("FAIL reset_tready: got %b required 0", axis.tready); n_fail++; end
    n_checks++; if ({sdata_a, sdata_b, sdata_oe, frame_active, underrun, aborted} !== 6'b0) begin
      $display("FAIL reset_outputs: got %b required 000000", {sdata_a, sdata_b, sdata_oe, frame_active, underrun, aborted}); n_fail++; end
    n_checks++; if (frame_count !== 32'd0) begin $display("FAIL reset_frame_count: got %0d required 0", frame_count); n_fail++; end
    sreset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (axis.tready !== 1'b1) begin $display("FAIL reset_tready_after: got %b required 1", axis.tready); n_fail++; end
  endtask

  task automatic test_frame();
    int u0, a0;
    q.push_back(32'h0ABC_0123);
    wait_drained();
    n_checks++; if (axis.tready !== 1'b0) begin $display("FAIL frame_hold_full: tready %b required 0", axis.tready); n_fail++; end
    u0 = n_underrun; a0 = n_aborted;
    run_frame(16, 1'b0, 32'h0, 1'b1);
    n_checks++; if (cap_a !== 16'h048C) begin $display("FAIL frame_sdata_a: got %h required 048c", cap_a); n_fail++; end
    n_checks++; if (cap_b !== 16'h2AF0) begin $display("FAIL frame_sdata_b: got %h required 2af0", cap_b); n_fail++; end
    n_checks++; if (oe_mid !== 1'b1) begin $display("FAIL frame_oe_on: got %b required 1", oe_mid); n_fail++; end
    n_checks++; if (oe_at2 !== 1'b1) begin $display("FAIL frame_oe_2clk: got %b required 1", oe_at2); n_fail++; end
    n_checks++; if (oe_at3 !== 1'b0) begin $display("FAIL frame_oe_3clk: got %b required 0", oe_at3); n_fail++; end
    n_checks++; if (fa_before !== 1'b1 || fa_after !== 1'b0) begin
      $display("FAIL frame_active: got %b%b required 10", fa_before, fa_after); n_fail++; end
    n_checks++; if (frame_count !== 32'd1) begin $display("FAIL frame_count1: got %0d required 1", frame_count); n_fail++; end
    n_checks++; if (n_underrun - u0 !== 0 || n_aborted - a0 !== 0) begin
      $display("FAIL frame_pulses: underrun %0d aborted %0d required 0 0", n_underrun - u0, n_aborted - a0); n_fail++; end
    n_checks++; if (axis.tready !== 1'b1) begin $display("FAIL frame_hold_empty: tready %b required 1", axis.tready); n_fail++; end
  endtask

  task automatic test_underrun();
    int u0 = n_underrun;
    run_frame(16, 1'b0, 32'h0, 1'b1);
    n_checks++; if (cap_a !== 16'h048C || cap_b !== 16'h2AF0) begin
      $display("FAIL underrun_data: got %h %h required 048c 2af0", cap_a, cap_b); n_fail++; end
    n_checks++; if (n_underrun - u0 !== 1) begin $display("FAIL underrun_pulse: got %0d cycles required 1", n_underrun - u0); n_fail++; end
    n_checks++; if (frame_count !== 32'd2) begin $display("FAIL underrun_count: got %0d required 2", frame_count); n_fail++; end
  endtask

  task automatic test_abort();
    int u0, a0;
    q.push_back(32'h0456_0789);
    wait_drained();
    u0 = n_underrun; a0 = n_aborted;
    run_frame(7, 1'b0, 32'h0, 1'b1);
    n_checks++; if (cap_a !== 16'h000F || cap_b !== 16'h0008) begin
      $display("FAIL abort_partial: got %h %h required 000f 0008", cap_a, cap_b); n_fail++; end
    n_checks++; if (n_aborted - a0 !== 1) begin $display("FAIL abort_pulse: got %0d cycles required 1", n_aborted - a0); n_fail++; end
    n_checks++; if (oe_cs !== 1'b0 || fa_after !== 1'b0) begin
      $display("FAIL abort_oe: oe %b active %b required 0 0", oe_cs, fa_after); n_fail++; end
    n_checks++; if (frame_count !== 32'd2) begin $display("FAIL abort_count: got %0d required 2", frame_count); n_fail++; end
    q.push_back(32'h0DEF_0321);
    wait_drained();
    a0 = n_aborted;
    run_frame(16, 1'b0, 32'h0, 1'b1);
    n_checks++; if (cap_a !== 16'h0C84 || cap_b !== 16'h37BC) begin
      $display("FAIL abort_next_data: got %h %h required 0c84 37bc", cap_a, cap_b); n_fail++; end
    n_checks++; if (n_underrun - u0 !== 0 || n_aborted - a0 !== 0) begin
      $display("FAIL abort_next_pulses: underrun %0d aborted %0d required 0 0", n_underrun - u0, n_aborted - a0); n_fail++; end
    n_checks++; if (frame_count !== 32'd3) begin $display("FAIL abort_next_count: got %0d required 3", frame_count); n_fail++; end
  endtask

  task automatic test_backpressure();
    int u0 = n_underrun;
    q.push_back(32'h0111_0222);
    q.push_back(32'h0333_0444);
    repeat (10) @(negedge clk);
    n_checks++; if (axis.tready !== 1'b0 || axis.tvalid !== 1'b1) begin
      $display("FAIL bp_stall: tready %b tvalid %b required 0 1", axis.tready, axis.tvalid); n_fail++; end
    n_checks++; if (q.size() !== 1) begin $display("FAIL bp_pending: queue %0d required 1", q.size()); n_fail++; end
    run_frame(16, 1'b0, 32'h0, 1'b1);
    n_checks++; if (cap_a !== 16'h0888 || cap_b !== 16'h0444) begin
      $display("FAIL bp_first: got %h %h required 0888 0444", cap_a, cap_b); n_fail++; end
    n_checks++; if (q.size() !== 0 || axis.tready !== 1'b0) begin
      $display("FAIL bp_refill: queue %0d tready %b required 0 0", q.size(), axis.tready); n_fail++; end
    run_frame(16, 1'b0, 32'h0, 1'b1);
    n_checks++; if (cap_a !== 16'h1110 || cap_b !== 16'h0CCC) begin
      $display("FAIL bp_second: got %h %h required 1110 0ccc", cap_a, cap_b); n_fail++; end
    n_checks++; if (n_underrun - u0 !== 0 || frame_count !== 32'd5) begin
      $display("FAIL bp_status: underrun %0d count %0d required 0 5", n_underrun - u0, frame_count); n_fail++; end
  endtask

  task automatic test_bypass();
    int u0 = n_underrun;
    run_frame(16, 1'b1, 32'h0555_0666, 1'b1);
    n_checks++; if (cap_a !== 16'h1998 || cap_b !== 16'h1554) begin
      $display("FAIL bypass_data: got %h %h required 1998 1554", cap_a, cap_b); n_fail++; end
    n_checks++; if (n_underrun - u0 !== 0) begin $display("FAIL bypass_underrun: got %0d required 0", n_underrun - u0); n_fail++; end
    n_checks++; if (axis.tready !== 1'b1 || q.size() !== 0) begin
      $display("FAIL bypass_hold: tready %b queue %0d required 1 0", axis.tready, q.size()); n_fail++; end
    n_checks++; if (frame_count !== 32'd6) begin $display("FAIL bypass_count: got %0d required 6", frame_count); n_fail++; end
  endtask

  task automatic test_sreset();
    int u0;
    run_frame(9, 1'b0, 32'h0, 1'b0);
    n_checks++; if (sdata_oe !== 1'b1) begin $display("FAIL sreset_pre_oe: got %b required 1", sdata_oe); n_fail++; end
    sreset = 1'b1;
    cs_n   = 1'b1;
    @(negedge clk);
    n_checks++; if ({sdata_a, sdata_b, sdata_oe, frame_active, underrun, aborted, axis.tready} !== 7'b0) begin
      $display("FAIL sreset_outputs: got %b required 0000000",
               {sdata_a, sdata_b, sdata_oe, frame_active, underrun, aborted, axis.tready}); n_fail++; end
    n_checks++; if (frame_count !== 32'd0) begin $display("FAIL sreset_count: got %0d required 0", frame_count); n_fail++; end
    repeat (2) @(negedge clk);
    sreset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (axis.tready !== 1'b1) begin $display("FAIL sreset_tready: got %b required 1", axis.tready); n_fail++; end
    u0 = n_underrun;
    run_frame(16, 1'b0, 32'h0, 1'b1);
    n_checks++; if (cap_a !== 16'h0000 || cap_b !== 16'h0000) begin
      $display("FAIL sreset_last_zero: got %h %h required 0000 0000", cap_a, cap_b); n_fail++; end
    n_checks++; if (n_underrun - u0 !== 1 || frame_count !== 32'd1) begin
      $display("FAIL sreset_next: underrun %0d count %0d required 1 1", n_underrun - u0, frame_count); n_fail++; end
  endtask

`ifdef AD7276_EMU_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [15:0] exp_a[3] = '{16'h0000, 16'h0004, 16'h0008};
    logic [15:0] exp_b[3] = '{16'h3FFC, 16'h3FF8, 16'h3FF4};
    int u0;
    @(negedge clk);
    sreset = 1'b1;
    repeat (2) @(negedge clk);
    sreset = 1'b0;
    pattern_en = 1'b1;
    q.push_back(32'h0FFF_0FFF);
    u0 = n_underrun;
    for (int f = 0; f < 3; f++) begin
      run_frame(16, 1'b0, 32'h0, 1'b1);
      n_checks++; if (cap_a !== exp_a[f] || cap_b !== exp_b[f]) begin
        $display("FAIL pattern_frame%0d: got %h %h required %h %h", f, cap_a, cap_b, exp_a[f], exp_b[f]); n_fail++; end
    end
    n_checks++; if (n_underrun - u0 !== 0) begin $display("FAIL pattern_underrun: got %0d required 0", n_underrun - u0); n_fail++; end
    pattern_en = 1'b0;
  endtask
`endif

  initial begin
    sreset = 1'b1;
    cs_n   = 1'b1;
    sclk   = 1'b0;
`ifdef AD7276_EMU_TEST_PATTERN_EN
    pattern_en = 1'b0;
`endif
    test_reset();
    test_frame();
    test_underrun();
    test_abort();
    test_backpressure();
    test_bypass();
    test_sreset();
`ifdef AD7276_EMU_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
